// File: rtl/audio_dc_block_if.sv
// audio_dc_block_if
//   Groups the audio data, bypass control and sample/clip status of the
//   stereo DC-blocking filter.
//   audio_l_i / audio_r_i : 12-bit unsigned offset-binary inputs (0x800 = silence)
//   bypass_i              : 1 = pass inputs through unfiltered
//   audio_l_o / audio_r_o : 12-bit unsigned offset-binary filtered outputs
//   sample_o              : one-cycle pulse when both outputs update
//   clip_o                : either channel saturated in the last sample
//   slave  : the filter side; master : the producer/consumer side.
interface audio_dc_block_if;
  logic [11:0] audio_l_i;
  logic [11:0] audio_r_i;
  logic        bypass_i;
  logic [11:0] audio_l_o;
  logic [11:0] audio_r_o;
  logic        sample_o;
  logic        clip_o;

  modport slave (
    input  audio_l_i, audio_r_i, bypass_i,
    output audio_l_o, audio_r_o, sample_o, clip_o
  );

  modport master (
    output audio_l_i, audio_r_i, bypass_i,
    input  audio_l_o, audio_r_o, sample_o, clip_o
  );
endinterface

// File: rtl/audio_dc_block.sv
// audio_dc_block
//   Stereo DC-blocking high-pass filter with output saturation. Inputs are
//   sampled once every CE_DIV clocks; one shared arithmetic path processes the
//   left channel, then the right, and both outputs update together.
//   Ports:
//     clk_sys  : system clock
//     reset_n  : asynchronous active-low reset
//     aud      : audio_dc_block_if.slave (audio in/out, bypass, sample/clip)
//   Parameters:
//     CE_DIV   : clocks per sample strobe (>= 4)
//     K        : pole shift, y -= y >>> K per sample (4..12)
module audio_dc_block #(
  parameter int unsigned CE_DIV = 583,
  parameter int unsigned K      = 8
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  audio_dc_block_if.slave aud
);

  localparam int unsigned ACC_W = 14 + K;
  localparam int unsigned CNT_W = $clog2(CE_DIV);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(CE_DIV - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] Y_MIN    = ACC_W'(-2048);

  typedef enum logic [1:0] {
    IDLE,
    CALC_L,
    CALC_R,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe;

  logic [11:0] cap_l_q, cap_r_q;
  logic        cap_byp_q;

  logic signed [11:0]      xprev_l_q, xprev_r_q;
  logic signed [ACC_W-1:0] acc_l_q, acc_r_q;

  // Left result is parked here so both outputs can change on the same edge.
  logic [11:0] stage_l_q;
  logic        clip_l_q;

  logic [11:0] out_l_q, out_r_q;
  logic        sample_q, clip_q;

  logic cap_en, ld_l, ld_r;

  logic                    sel_r;
  logic [11:0]             x_raw;
  logic signed [11:0]      x_s, x_prev;
  logic signed [12:0]      d;
  logic signed [ACC_W-1:0] acc, d_sh, acc_new, y_full, y_sat;
  logic [11:0]             ch_out;
  logic                    ch_clip;

  // Sample-rate divider
  always_comb begin
    strobe = (cnt_q == CNT_LAST);
    cnt_d  = strobe ? '0 : cnt_q + 1'b1;
  end

  // FSM next state and per-state enables
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    ld_l    = 1'b0;
    ld_r    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          cap_en  = 1'b1;
          state_d = CALC_L;
        end
      end
      CALC_L: begin
        ld_l    = 1'b1;
        state_d = CALC_R;
      end
      CALC_R: begin
        ld_r    = 1'b1;
        state_d = OUT;
      end
      OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared per-channel datapath, steered by the current CALC state
  always_comb begin
    sel_r  = (state_q == CALC_R);
    x_raw  = sel_r ? cap_r_q   : cap_l_q;
    x_prev = sel_r ? xprev_r_q : xprev_l_q;
    acc    = sel_r ? acc_r_q   : acc_l_q;

    x_s     = {~x_raw[11], x_raw[10:0]};
    d       = {x_s[11], x_s} - {x_prev[11], x_prev};
    d_sh    = {{(ACC_W-13){d[12]}}, d} <<< K;
    acc_new = acc + d_sh - (acc >>> K);
    y_full  = acc_new >>> K;

    y_sat   = y_full;
    ch_clip = 1'b0;
    if (y_full > Y_MAX) begin
      y_sat   = Y_MAX;
      ch_clip = 1'b1;
    end else if (y_full < Y_MIN) begin
      y_sat   = Y_MIN;
      ch_clip = 1'b1;
    end

    // Bypass only replaces the output; filter state still advances.
    if (cap_byp_q) begin
      ch_out  = x_raw;
      ch_clip = 1'b0;
    end else begin
      ch_out  = {~y_sat[11], y_sat[10:0]};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_l_q   <= 12'h800;
      cap_r_q   <= 12'h800;
      cap_byp_q <= 1'b0;
      xprev_l_q <= '0;
      xprev_r_q <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      stage_l_q <= 12'h800;
      clip_l_q  <= 1'b0;
      out_l_q   <= 12'h800;
      out_r_q   <= 12'h800;
      sample_q  <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= ld_r;
      if (cap_en) begin
        cap_l_q   <= aud.audio_l_i;
        cap_r_q   <= aud.audio_r_i;
        cap_byp_q <= aud.bypass_i;
      end
      if (ld_l) begin
        xprev_l_q <= x_s;
        acc_l_q   <= acc_new;
        stage_l_q <= ch_out;
        clip_l_q  <= ch_clip;
      end
      // Outputs load on the CALC_R->OUT edge so they are valid during OUT,
      // three cycles after the strobe.
      if (ld_r) begin
        xprev_r_q <= x_s;
        acc_r_q   <= acc_new;
        out_l_q   <= stage_l_q;
        out_r_q   <= ch_out;
        clip_q    <= clip_l_q | ch_clip;
      end
    end
  end

  assign aud.audio_l_o = out_l_q;
  assign aud.audio_r_o = out_r_q;
  assign aud.sample_o  = sample_q;
  assign aud.clip_o    = clip_q;

endmodule

// File: tb/tb_audio_dc_block.sv
// tb_audio_dc_block
//   Self-checking bench for audio_dc_block with a short sample period.
//   Expected outputs are produced by a reference model when each sample is
//   strobed and queued; a monitor pops and compares them on every sample_o.
module tb_audio_dc_block;
  localparam int CE = 8;
  localparam int KS = 8;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  audio_dc_block_if aud ();

  audio_dc_block #(.CE_DIV(CE), .K(KS)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .aud     (aud)
  );

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    logic        clip;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bcnt   = 0;

  int     xp_l, xp_r;
  longint acc_l, acc_r;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Expected divider position, so the driver knows the strobe cycle
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) bcnt <= 0;
    else          bcnt <= (bcnt == CE - 1) ? 0 : bcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    xp_l = 0; xp_r = 0; acc_l = 0; acc_r = 0;
  endtask

  // Reference filter: offset-binary x is x-2048 in two's complement
  task automatic model_ch(input int x, inout int xp, inout longint acc,
                          output int y_out, output bit clp);
    int     xs;
    int     d;
    longint y;
    xs  = x - 2048;
    d   = xs - xp;
    acc = acc + longint'(d) * (longint'(1) << KS) - (acc >>> KS);
    xp  = xs;
    y   = acc >>> KS;
    clp = 1'b0;
    if (y > 2047) begin
      y = 2047; clp = 1'b1;
    end else if (y < -2048) begin
      y = -2048; clp = 1'b1;
    end
    y_out = int'(y) + 2048;
  endtask

  task automatic wiggle_inputs();
    aud.audio_l_i = 12'($urandom_range(0, 4095));
    aud.audio_r_i = 12'($urandom_range(0, 4095));
    aud.bypass_i  = 1'($urandom_range(0, 1));
  endtask

  // Drive final values on the strobe cycle; queue the model's prediction
  task automatic strobe_only(input logic [11:0] l, input logic [11:0] r,
                             input logic byp, input bit wiggle);
    int   n;
    int   ol, orr;
    bit   cl, cr;
    exp_t e;
    aud.audio_l_i = l; aud.audio_r_i = r; aud.bypass_i = byp;
    n = 0;
    forever begin
      @(negedge clk_sys);
      if (bcnt == CE - 1) break;
      n++;
      if (n > CE + 4) begin
        $display("FAIL strobe_wait no strobe within %0d cycles", n);
        $fatal(1, "strobe wait expired");
      end
      if (wiggle) wiggle_inputs();
    end
    aud.audio_l_i = l; aud.audio_r_i = r; aud.bypass_i = byp;
    model_ch(int'(l), xp_l, acc_l, ol, cl);
    model_ch(int'(r), xp_r, acc_r, orr, cr);
    if (byp) begin
      e.l = l; e.r = r; e.clip = 1'b0;
    end else begin
      e.l = 12'(ol); e.r = 12'(orr); e.clip = cl | cr;
    end
    e.cyc = cyc + 3;
    sbq.push_back(e);
  endtask

  task automatic wait_pulse(input bit wiggle);
    int waited;
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
      if (wiggle) wiggle_inputs();
    end while (aud.sample_o !== 1'b1 && waited < 8);
    chk("pulse_seen", 32'(aud.sample_o), 32'd1);
  endtask

  task automatic sample(input logic [11:0] l, input logic [11:0] r,
                        input logic byp, input bit wiggle);
    strobe_only(l, r, byp, wiggle);
    wait_pulse(wiggle);
  endtask

  // Scoreboard: every pulse must match the oldest queued prediction
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n === 1'b1 && aud.sample_o === 1'b1) begin
      chk("pulse_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("out_l", 32'(aud.audio_l_o), 32'(e.l));
        chk("out_r", 32'(aud.audio_r_o), 32'(e.r));
        chk("clip", 32'(aud.clip_o), 32'(e.clip));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int          rel;
    logic [11:0] prev;
    logic [11:0] lv;

    reset_n       = 1'b0;
    aud.audio_l_i = 12'h800;
    aud.audio_r_i = 12'h800;
    aud.bypass_i  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("rst_l", 32'(aud.audio_l_o), 32'h800);
    chk("rst_r", 32'(aud.audio_r_o), 32'h800);
    chk("rst_sample", 32'(aud.sample_o), 32'd0);
    chk("rst_clip", 32'(aud.clip_o), 32'd0);

    // Silence in, silence out; first pulse CE_DIV-1+3 cycles after release
    reset_n = 1'b1;
    rel = cyc;
    strobe_only(12'h800, 12'h800, 1'b0, 1'b0);
    wait_pulse(1'b0);
    chk("first_pulse_latency", 32'(cyc - rel), 32'(CE + 2));
    repeat (4) sample(12'h800, 12'h800, 1'b0, 1'b0);

    // Step on left: 0xC00, 0xBFC, then monotonic decay to silence
    sample(12'hC00, 12'h800, 1'b0, 1'b0);
    chk("step_s1", 32'(aud.audio_l_o), 32'hC00);
    sample(12'hC00, 12'h800, 1'b0, 1'b0);
    chk("step_s2", 32'(aud.audio_l_o), 32'hBFC);
    prev = aud.audio_l_o;
    for (int i = 2; i < 3000; i++) begin
      sample(12'hC00, 12'h800, 1'b0, 1'b0);
      chk("decay_mono", 32'(aud.audio_l_o <= prev), 32'd1);
      prev = aud.audio_l_o;
    end
    chk("decay_settled", 32'(aud.audio_l_o >= 12'h7FF && aud.audio_l_o <= 12'h801), 32'd1);

    // Full-scale steps in opposite directions on both channels
    for (int i = 0; i < 2000; i++) sample(12'h000, 12'hFFF, 1'b0, 1'b0);
    sample(12'hFFF, 12'h000, 1'b0, 1'b0);
    chk("sat_l", 32'(aud.audio_l_o), 32'hFFF);
    chk("sat_r", 32'(aud.audio_r_o), 32'h000);
    chk("sat_clip", 32'(aud.clip_o), 32'd1);
    for (int i = 0; i < 250; i++) sample(12'hFFF, 12'h000, 1'b0, 1'b0);
    chk("unsat_clip", 32'(aud.clip_o), 32'd0);

    // Bypass, with bypass/inputs toggling between strobes
    sample(12'h9AB, 12'h123, 1'b1, 1'b0);
    chk("byp_r", 32'(aud.audio_r_o), 32'h123);
    chk("byp_l", 32'(aud.audio_l_o), 32'h9AB);
    sample(12'hA00, 12'h123, 1'b1, 1'b1);
    chk("byp_hold_r", 32'(aud.audio_r_o), 32'h123);
    sample(12'h800, 12'h800, 1'b0, 1'b1);
    sample(12'h800, 12'h123, 1'b1, 1'b1);

    // Inputs changing every cycle: only strobe-cycle values count
    for (int i = 0; i < 6; i++) begin
      lv = 12'($urandom_range(0, 4095));
      sample(lv, 12'h800, 1'b0, 1'b1);
    end

    // Reset during CALC_R aborts the sample
    strobe_only(12'h456, 12'h321, 1'b0, 1'b0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("abort_l", 32'(aud.audio_l_o), 32'h800);
    chk("abort_r", 32'(aud.audio_r_o), 32'h800);
    chk("abort_sample", 32'(aud.sample_o), 32'd0);
    chk("abort_clip", 32'(aud.clip_o), 32'd0);
    sbq.delete();
    model_reset();
    repeat (3) begin
      @(negedge clk_sys);
      chk("abort_no_pulse", 32'(aud.sample_o), 32'd0);
    end
    reset_n = 1'b1;
    rel = cyc;
    strobe_only(12'h800, 12'h800, 1'b0, 1'b0);
    wait_pulse(1'b0);
    chk("rerelease_latency", 32'(cyc - rel), 32'(CE + 2));
    sample(12'h900, 12'h700, 1'b0, 1'b0);
    sample(12'h900, 12'h700, 1'b0, 1'b0);

    repeat (2) @(negedge clk_sys);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
